// File: rtl/pitch_swing_sequencer.sv
// Pitch/swing sequencer for a two-player table baseball game: drives the throw
// and hit motors from keyboard pulses and keeps the outs / batting-side score.
module pitch_swing_sequencer #(
    parameter int T_THROW       = 12500000,
    parameter int T_WINDOW      = 25000000,
    parameter int T_HIT         = 8388608,
    parameter int T_HOLD        = 67108864,
    parameter int T_RETURN      = 8388608,
    parameter int OUTS_PER_SIDE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_left,
    input  logic       key_right,
    output logic [1:0] hit_mode,
    output logic       throw_on,
    output logic       batter,
    output logic [1:0] outs,
    output logic       side_change,
    output logic       busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WINDOW = 3'd1;
    localparam logic [2:0] S_HIT    = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_RET    = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam int PHASE_MAX_A = (T_WINDOW > T_HIT) ? T_WINDOW : T_HIT;
    localparam int PHASE_MAX_B = (T_HOLD > T_RETURN) ? T_HOLD : T_RETURN;
    localparam int PHASE_MAX   = (PHASE_MAX_A > PHASE_MAX_B) ? PHASE_MAX_A : PHASE_MAX_B;
    localparam int PW          = $clog2(PHASE_MAX + 1);
    localparam int TW          = $clog2(T_THROW + 1);

    localparam logic [PW-1:0] WINDOW_LAST = PW'(T_WINDOW - 1);
    localparam logic [PW-1:0] HIT_LAST    = PW'(T_HIT - 1);
    localparam logic [PW-1:0] HOLD_LAST   = PW'(T_HOLD - 1);
    localparam logic [PW-1:0] RETURN_LAST = PW'(T_RETURN - 1);
    localparam logic [TW-1:0] THROW_LAST  = TW'(T_THROW - 1);
    localparam logic [2:0]    OUTS_LIMIT  = 3'(OUTS_PER_SIDE);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [PW-1:0] phase_cnt;
    logic [PW-1:0] phase_nxt;
    logic [TW-1:0] throw_cnt;
    logic [2:0]    outs_inc;
    logic [1:0]    mode_nxt;
    logic          pitch_key;
    logic          swing_key;

    // The batting player swings; the other player's key is the pitch.
    assign pitch_key = batter ? key_left  : key_right;
    assign swing_key = batter ? key_right : key_left;
    assign outs_inc  = {1'b0, outs} + 3'd1;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (pitch_key) state_nxt = S_WINDOW;
            S_WINDOW: begin
                if (swing_key)                      state_nxt = S_HIT;
                else if (phase_cnt == WINDOW_LAST)  state_nxt = S_OUT;
            end
            S_HIT:    if (phase_cnt == HIT_LAST)    state_nxt = S_HOLD;
            S_HOLD:   if (phase_cnt == HOLD_LAST)   state_nxt = S_RET;
            S_RET:    if (phase_cnt == RETURN_LAST) state_nxt = S_DONE;
            S_OUT:    state_nxt = S_DONE;
            S_DONE:   if (!throw_on)                state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Phase counter restarts on every state entry and only runs in timed states.
    always_comb begin
        phase_nxt = '0;
        if (state_nxt == state &&
            (state == S_WINDOW || state == S_HIT || state == S_HOLD || state == S_RET))
            phase_nxt = phase_cnt + 1'b1;
    end

    always_comb begin
        mode_nxt = 2'd0;
        case (state_nxt)
            S_HIT:   mode_nxt = 2'd1;
            S_HOLD:  mode_nxt = 2'd2;
            S_RET:   mode_nxt = 2'd3;
            default: mode_nxt = 2'd0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            phase_cnt   <= '0;
            throw_cnt   <= '0;
            hit_mode    <= 2'd0;
            throw_on    <= 1'b0;
            batter      <= 1'b0;
            outs        <= 2'd0;
            side_change <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            phase_cnt   <= phase_nxt;
            hit_mode    <= mode_nxt;
            busy        <= (state_nxt != S_IDLE);
            side_change <= 1'b0;

            // Throw timer runs on its own; only a pitch accepted in IDLE starts it.
            if (state == S_IDLE && state_nxt == S_WINDOW) begin
                throw_on  <= 1'b1;
                throw_cnt <= '0;
            end else if (throw_on) begin
                if (throw_cnt == THROW_LAST) begin
                    throw_on  <= 1'b0;
                    throw_cnt <= '0;
                end else begin
                    throw_cnt <= throw_cnt + 1'b1;
                end
            end

            if (state_nxt == S_OUT) begin
                if (outs_inc == OUTS_LIMIT) begin
                    outs        <= 2'd0;
                    batter      <= ~batter;
                    side_change <= 1'b1;
                end else begin
                    outs <= outs_inc[1:0];
                end
            end
        end
    end

endmodule
